rooth_test_monitor: RTL and testbench

- Synthesizable self-check monitor for the rooth core; runs on FPGA or in simulation without hierarchical probes.
- Snoops the register-file write port and sequences one test per start request: core reset pulse, run, signature capture, result report.
- Generalised over signature register indices, timeout, settle window and counter widths.
- Keeps running pass/fail/timeout totals across back-to-back tests.

---
 rtl/rooth_test_monitor_pkg.sv | 17 +
 rtl/rooth_sig_snoop.sv | 54 +++++
 rtl/rooth_test_monitor.sv | 165 ++++++++++++++++
 tb/tb_rooth_test_monitor.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rooth_test_monitor_pkg.sv
// Shared types and default register indices for the rooth self-check monitor.
package rooth_test_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CORE_RST = 3'd1,
    S_RUN      = 3'd2,
    S_SETTLE   = 3'd3,
    S_REPORT   = 3'd4
  } state_t;

  localparam int DEF_CPU_WIDTH = 32;
  localparam int DEF_DONE_REG  = 26;
  localparam int DEF_PASS_REG  = 27;
  localparam int DEF_TNUM_REG  = 3;

endpackage

// File: rtl/rooth_sig_snoop.sv
// Register-file write snooper: signature shadows and done-event detection.
module rooth_sig_snoop
  import rooth_test_monitor_pkg::*;
#(
  parameter int CPU_WIDTH = DEF_CPU_WIDTH,
  parameter int DONE_REG  = DEF_DONE_REG,
  parameter int PASS_REG  = DEF_PASS_REG,
  parameter int TNUM_REG  = DEF_TNUM_REG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 wen,
  input  logic [4:0]           waddr,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [CPU_WIDTH-1:0] tnum,
  output logic                 pass_flag,
  output logic                 done_evt
);

  localparam logic [4:0] DONE_A = 5'(DONE_REG);
  localparam logic [4:0] PASS_A = 5'(PASS_REG);
  localparam logic [4:0] TNUM_A = 5'(TNUM_REG);
  localparam logic [CPU_WIDTH-1:0] ONE = CPU_WIDTH'(1);

  logic                 hit;
  logic [CPU_WIDTH-1:0] tnum_q;
  logic [CPU_WIDTH-1:0] pass_q;
  logic [CPU_WIDTH-1:0] pass_nxt;

  assign hit = en && wen && (waddr != 5'd0);

  // Shadows forward the current write so a same-cycle update is visible.
  assign tnum     = (hit && waddr == TNUM_A) ? wdata : tnum_q;
  assign pass_nxt = (hit && waddr == PASS_A) ? wdata : pass_q;

  assign pass_flag = (pass_nxt == ONE);
  assign done_evt  = hit && (waddr == DONE_A) && (wdata == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tnum_q <= '0;
      pass_q <= '0;
    end else if (clr) begin
      tnum_q <= '0;
      pass_q <= '0;
    end else begin
      tnum_q <= tnum;
      pass_q <= pass_nxt;
    end
  end

endmodule

// File: rtl/rooth_test_monitor.sv
// Test sequencer: core reset, run, signature capture and verdict reporting.
module rooth_test_monitor
  import rooth_test_monitor_pkg::*;
#(
  parameter int CPU_WIDTH      = DEF_CPU_WIDTH,
  parameter int DONE_REG       = DEF_DONE_REG,
  parameter int PASS_REG       = DEF_PASS_REG,
  parameter int TNUM_REG       = DEF_TNUM_REG,
  parameter int RST_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_WIDTH      = 16,
  parameter int ID_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [ID_WIDTH-1:0]  test_id_i,
  input  logic                 reg_wen_i,
  input  logic [4:0]           reg_waddr_i,
  input  logic [CPU_WIDTH-1:0] reg_wdata_i,
  output logic                 core_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [ID_WIDTH-1:0]  test_id_o,
  output logic [CPU_WIDTH-1:0] fail_tnum_o,
  output logic [CNT_WIDTH-1:0] cycles_o,
  output logic [CNT_WIDTH-1:0] pass_cnt_o,
  output logic [CNT_WIDTH-1:0] fail_cnt_o,
  output logic [CNT_WIDTH-1:0] tmo_cnt_o
);

  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int XW   = (TW > CNT_WIDTH) ? TW : CNT_WIDTH;
  localparam int PMAX = (RST_CYCLES > SETTLE_CYCLES) ?
                        RST_CYCLES : SETTLE_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [XW-1:0] CNT_MAX  = XW'({CNT_WIDTH{1'b1}});
  localparam logic [XW-1:0] TMO_LAST = XW'(TIMEOUT_CYCLES - 1);
  localparam logic [XW-1:0] TMO_VAL  = XW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] RST_LAST = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] STL_LAST = PW'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [PW-1:0]        ph_cnt;
  logic [XW-1:0]        run_cnt;
  logic [CPU_WIDTH-1:0] tnum;
  logic                 pass_flag;
  logic                 done_evt;
  logic                 snoop_clr;
  logic                 snoop_en;

  function automatic logic [CNT_WIDTH-1:0] sat(input logic [XW-1:0] v);
    return (v > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : v[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] inc_sat(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign snoop_clr = (state == S_IDLE) && start_i;
  assign snoop_en  = (state == S_RUN) || (state == S_SETTLE);
  assign busy_o    = (state != S_IDLE);

  rooth_sig_snoop #(
    .CPU_WIDTH (CPU_WIDTH),
    .DONE_REG  (DONE_REG),
    .PASS_REG  (PASS_REG),
    .TNUM_REG  (TNUM_REG)
  ) u_snoop (
    .clk       (clk),
    .rst       (rst),
    .clr       (snoop_clr),
    .en        (snoop_en),
    .wen       (reg_wen_i),
    .waddr     (reg_waddr_i),
    .wdata     (reg_wdata_i),
    .tnum      (tnum),
    .pass_flag (pass_flag),
    .done_evt  (done_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ph_cnt      <= '0;
      run_cnt     <= '0;
      core_rst_o  <= 1'b1;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      timeout_o   <= 1'b0;
      test_id_o   <= '0;
      fail_tnum_o <= '0;
      cycles_o    <= '0;
      pass_cnt_o  <= '0;
      fail_cnt_o  <= '0;
      tmo_cnt_o   <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            state     <= S_CORE_RST;
            ph_cnt    <= '0;
            test_id_o <= test_id_i;
            pass_o    <= 1'b0;
            fail_o    <= 1'b0;
            timeout_o <= 1'b0;
          end
        end
        S_CORE_RST: begin
          if (ph_cnt == RST_LAST) begin
            state      <= S_RUN;
            core_rst_o <= 1'b0;
            run_cnt    <= '0;
          end else begin
            ph_cnt <= ph_cnt + PW'(1);
          end
        end
        S_RUN: begin
          // A done write on the timeout boundary still counts as done.
          if (done_evt) begin
            state    <= S_SETTLE;
            ph_cnt   <= '0;
            cycles_o <= sat(run_cnt);
          end else if (run_cnt == TMO_LAST) begin
            state       <= S_REPORT;
            core_rst_o  <= 1'b1;
            done_o      <= 1'b1;
            timeout_o   <= 1'b1;
            fail_tnum_o <= tnum;
            cycles_o    <= sat(TMO_VAL);
            tmo_cnt_o   <= inc_sat(tmo_cnt_o);
          end else begin
            run_cnt <= run_cnt + XW'(1);
          end
        end
        S_SETTLE: begin
          if (ph_cnt == STL_LAST) begin
            state       <= S_REPORT;
            core_rst_o  <= 1'b1;
            done_o      <= 1'b1;
            pass_o      <= pass_flag;
            fail_o      <= !pass_flag;
            fail_tnum_o <= tnum;
            if (pass_flag) pass_cnt_o <= inc_sat(pass_cnt_o);
            else           fail_cnt_o <= inc_sat(fail_cnt_o);
          end else begin
            ph_cnt <= ph_cnt + PW'(1);
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rooth_test_monitor.sv
// Scoreboard bench for rooth_test_monitor with randomized write schedules.
module tb_rooth_test_monitor;

  localparam int W  = 32;
  localparam int T  = 100;
  localparam int RC = 2;
  localparam int SC = 1;
  localparam int CW = 16;
  localparam int IW = 8;
  localparam int SL = T + SC;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [IW-1:0] test_id_i;
  logic          reg_wen_i;
  logic [4:0]    reg_waddr_i;
  logic [W-1:0]  reg_wdata_i;
  logic          core_rst_o;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic          fail_o;
  logic          timeout_o;
  logic [IW-1:0] test_id_o;
  logic [W-1:0]  fail_tnum_o;
  logic [CW-1:0] cycles_o;
  logic [CW-1:0] pass_cnt_o;
  logic [CW-1:0] fail_cnt_o;
  logic [CW-1:0] tmo_cnt_o;

  always #5 clk = ~clk;

  rooth_test_monitor #(
    .CPU_WIDTH      (W),
    .DONE_REG       (26),
    .PASS_REG       (27),
    .TNUM_REG       (3),
    .RST_CYCLES     (RC),
    .SETTLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (T),
    .CNT_WIDTH      (CW),
    .ID_WIDTH       (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .test_id_i   (test_id_i),
    .reg_wen_i   (reg_wen_i),
    .reg_waddr_i (reg_waddr_i),
    .reg_wdata_i (reg_wdata_i),
    .core_rst_o  (core_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .test_id_o   (test_id_o),
    .fail_tnum_o (fail_tnum_o),
    .cycles_o    (cycles_o),
    .pass_cnt_o  (pass_cnt_o),
    .fail_cnt_o  (fail_cnt_o),
    .tmo_cnt_o   (tmo_cnt_o)
  );

  typedef struct {
    logic [IW-1:0] id;
    bit            pass;
    bit            fail;
    bit            tmo;
    logic [W-1:0]  tnum;
    int            cyc;
    int            pc;
    int            fc;
    int            tc;
  } exp_t;

  exp_t expq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int m_pc   = 0;
  int m_fc   = 0;
  int m_tc   = 0;

  bit           s_en[SL];
  logic [4:0]   s_a[SL];
  logic [W-1:0] s_d[SL];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic clear_sched();
    for (int k = 0; k < SL; k++) begin
      s_en[k] = 1'b0;
      s_a[k]  = 5'd0;
      s_d[k]  = '0;
    end
  endtask

  task automatic set_wr(input int k, input logic [4:0] a,
                        input logic [W-1:0] d);
    s_en[k] = 1'b1;
    s_a[k]  = a;
    s_d[k]  = d;
  endtask

  task automatic drive(input bit en, input logic [4:0] a,
                       input logic [W-1:0] d);
    reg_wen_i   = en;
    reg_waddr_i = a;
    reg_wdata_i = d;
  endtask

  // Reference: first x26=1 in the run window ends the test; shadows take
  // the last nonzero-address write up to the end of the settle window.
  function automatic exp_t predict(input logic [IW-1:0] id, output int last);
    exp_t e;
    int d;
    logic [W-1:0] tn;
    logic [W-1:0] ps;
    d  = -1;
    tn = '0;
    ps = '0;
    for (int k = 0; k < T; k++)
      if (d < 0 && s_en[k] && s_a[k] == 5'd26 && s_d[k] == 32'd1) d = k;
    last = (d < 0) ? T - 1 : d + SC;
    for (int k = 0; k <= last; k++)
      if (s_en[k] && s_a[k] != 5'd0) begin
        if (s_a[k] == 5'd3)  tn = s_d[k];
        if (s_a[k] == 5'd27) ps = s_d[k];
      end
    e.id   = id;
    e.tmo  = (d < 0);
    e.pass = (d >= 0) && (ps == 32'd1);
    e.fail = (d >= 0) && (ps != 32'd1);
    e.tnum = tn;
    e.cyc  = (d < 0) ? T : d;
    e.pc   = 0;
    e.fc   = 0;
    e.tc   = 0;
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_core_rst"}, core_rst_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_fail"}, fail_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
    chk({tag, "_test_id"}, test_id_o, 0);
    chk({tag, "_tnum"}, fail_tnum_o, 0);
    chk({tag, "_cycles"}, cycles_o, 0);
    chk({tag, "_pass_cnt"}, pass_cnt_o, 0);
    chk({tag, "_fail_cnt"}, fail_cnt_o, 0);
    chk({tag, "_tmo_cnt"}, tmo_cnt_o, 0);
  endtask

  task automatic run_test(input logic [IW-1:0] id, input int abort_k);
    exp_t e;
    int last;
    int w;
    e = predict(id, last);
    if (abort_k < 0) begin
      if (e.pass) m_pc++;
      if (e.fail) m_fc++;
      if (e.tmo)  m_tc++;
      e.pc = m_pc;
      e.fc = m_fc;
      e.tc = m_tc;
      expq.push_back(e);
    end
    @(negedge clk);
    start_i   = 1'b1;
    test_id_i = id;
    @(negedge clk);
    start_i   = 1'b0;
    test_id_i = IW'($urandom);
    chk("core_rst_held", core_rst_o, 1);
    chk("busy_started", busy_o, 1);
    drive(1'b1, 5'd26, 32'd1);
    @(negedge clk);
    drive(1'b1, 5'd27, 32'd1);
    @(negedge clk);
    chk("core_rst_released", core_rst_o, 0);
    for (int k = 0; k <= last; k++) begin
      drive(s_en[k], s_a[k], s_d[k]);
      start_i = ($urandom % 16 == 0);
      if (k == abort_k) begin
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        drive(1'b0, 5'd0, '0);
        start_i = 1'b0;
        rst     = 1'b0;
        m_pc    = 0;
        m_fc    = 0;
        m_tc    = 0;
        return;
      end
      @(negedge clk);
    end
    drive(1'b0, 5'd0, '0);
    start_i = 1'b0;
    w = 0;
    while (busy_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("idle_after_test", busy_o, 0);
  endtask

  bit prev_done = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (prev_done) chk("done_pulse_width", done_o, 0);
    prev_done = done_o;
    if (done_o) begin
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done_o=1 expected no result");
      end else begin
        e = expq.pop_front();
        chk("pass", pass_o, e.pass);
        chk("fail", fail_o, e.fail);
        chk("timeout", timeout_o, e.tmo);
        chk("one_verdict",
            int'(pass_o) + int'(fail_o) + int'(timeout_o), 1);
        chk("test_id", test_id_o, e.id);
        chk("fail_tnum", fail_tnum_o, e.tnum);
        chk("cycles", cycles_o, e.cyc);
        chk("pass_cnt", pass_cnt_o, e.pc);
        chk("fail_cnt", fail_cnt_o, e.fc);
        chk("tmo_cnt", tmo_cnt_o, e.tc);
        chk("core_rst_report", core_rst_o, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]   a;
    logic [W-1:0] d;
    rst       = 1'b1;
    start_i   = 1'b0;
    test_id_i = '0;
    drive(1'b0, 5'd0, '0);
    clear_sched();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_core_rst", core_rst_o, 1);

    clear_sched();
    set_wr(5, 5'd3, 32'd7);
    set_wr(10, 5'd27, 32'd1);
    set_wr(40, 5'd26, 32'd1);
    run_test(8'd5, -1);

    clear_sched();
    set_wr(2, 5'd3, 32'd12);
    set_wr(3, 5'd27, 32'd0);
    set_wr(20, 5'd26, 32'd1);
    run_test(8'd6, -1);

    clear_sched();
    set_wr(1, 5'd3, 32'd9);
    set_wr(30, 5'd26, 32'd1);
    set_wr(31, 5'd27, 32'd1);
    run_test(8'd7, -1);

    clear_sched();
    set_wr(4, 5'd3, 32'd4);
    set_wr(6, 5'd0, 32'd1);
    set_wr(8, 5'd26, 32'd2);
    set_wr(9, 5'd27, 32'd1);
    run_test(8'd8, -1);

    clear_sched();
    set_wr(50, 5'd27, 32'd1);
    set_wr(99, 5'd26, 32'd1);
    run_test(8'd9, -1);

    clear_sched();
    set_wr(2, 5'd3, 32'd3);
    set_wr(98, 5'd26, 32'd5);
    run_test(8'd10, -1);

    clear_sched();
    set_wr(5, 5'd27, 32'd1);
    set_wr(60, 5'd26, 32'd1);
    run_test(8'd11, 30);

    clear_sched();
    set_wr(3, 5'd3, 32'd21);
    set_wr(4, 5'd27, 32'd1);
    set_wr(15, 5'd26, 32'd1);
    run_test(8'd12, -1);

    for (int t = 0; t < 20; t++) begin
      clear_sched();
      for (int k = 0; k < SL; k++) begin
        if ($urandom % 4 == 0) begin
          case ($urandom % 5)
            0:       a = 5'd0;
            1:       a = 5'd3;
            2:       a = 5'd27;
            3:       a = 5'd26;
            default: a = 5'($urandom);
          endcase
          if (a == 5'd26)      d = ($urandom % 8 == 0) ? 32'd1 : 32'd2;
          else if (a == 5'd27) d = W'($urandom % 3);
          else                 d = W'($urandom);
          set_wr(k, a, d);
        end
      end
      run_test(IW'($urandom), -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
